posit_fault_logger: RTL and testbench
=====================================

Name: posit_fault_logger

Overview:
- Sequential stage directly downstream of the posit add fault checker; samples its per-operation outputs (fault, mode, true/used sums and scales) once per valid cycle.
- Keeps saturating statistics counters and a consecutive-fault alarm FSM.
- Buffers faulting records in a FIFO drained by a valid/ready consumer (debug/log port).
- Drives force_full back to the checker control logic so it abandons truncated-mode checking while an alarm is active.

Parameters:
- NBITS, 32, posit width of true_sum/used_sum.
- DEPTH, 8, fault record FIFO depth; power of 2, >=2.
- CNT_W, 16, width of all statistic counters and rec_seq.
- ALARM_RUN, 4, consecutive faulting checks that raise alarm; 1..2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  checker outputs valid this cycle, one check per cycle, no backpressure
- in_fault  in  1  checker fault flag
- in_mode  in  1  1 = truncated adder used
- in_true_sum  in  NBITS  full-precision sum
- in_used_sum  in  NBITS  checker sum, zero-extended if truncated
- in_true_scale  in  7  scale of true sum
- in_used_scale  in  7  scale of used sum
- clr_alarm  in  1  clears sticky alarm and run counter
- rec_valid  out  1  FIFO head record valid
- rec_ready  in  1  consumer accepts head
- rec_mode / rec_true_sum / rec_used_sum / rec_true_scale / rec_used_scale  out  1/NBITS/NBITS/7/7  head record fields
- rec_seq  out  CNT_W  check index of head record
- chk_cnt  out  CNT_W  valid checks seen
- trunc_cnt  out  CNT_W  checks with in_mode=1
- fault_cnt  out  CNT_W  checks with in_fault=1
- drop_cnt  out  CNT_W  faulting records lost to full FIFO
- alarm  out  1  sticky alarm
- force_full  out  1  equals alarm, registered

Behaviour:
- Reset (sync, rst=1 at edge): all counters 0, FIFO empty, rec_valid=0, all rec_* fields 0, alarm=0, force_full=0, FSM=NORMAL. rst mid-operation discards FIFO contents and counters. Inputs are ignored during reset cycles.
- Counters update on in_valid: chk_cnt+1; trunc_cnt+1 if in_mode; fault_cnt+1 if in_fault. All counters saturate at 2^CNT_W-1, no wrap.
- rec_seq stores the chk_cnt value before increment, saturated value if saturated.
- FIFO write happens when in_valid & in_fault; a record holds all in_* fields plus seq.
- FIFO pop happens when rec_valid & rec_ready; the head advances next cycle.
- Full FIFO with a write and no pop: record dropped, drop_cnt+1 (saturating), contents unchanged.
- Full FIFO with simultaneous write and pop: both occur, no drop.
- Empty FIFO with a write: rec_valid=1 on the following cycle. Latency is 1 clk; there is no bypass.
- rec_* are stable while rec_valid=1 and rec_ready=0.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty use the MSB compare.
- run counter (internal, CNT_W): on in_valid&in_fault it increments, saturating. On in_valid&!in_fault it resets to 0. It holds when in_valid=0.
- FSM NORMAL -> ALARM on the edge where the run counter's next value reaches ALARM_RUN; alarm=1 from the following cycle.
- FSM ALARM -> NORMAL on clr_alarm=1, which also zeroes the run counter. If clr_alarm and a trigger occur in the same cycle, the clear applies first, then the current fault counts as run=1.
- clr_alarm in NORMAL zeroes the run counter only.
- Counters and FIFO keep operating in ALARM.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_fault=1 -> all outputs 0, rec_valid=0, alarm=0.
- Logging: 5 valid checks, faults on checks 1 and 3, mode=1 on all; rec_ready=1 -> chk_cnt=5, trunc_cnt=5, fault_cnt=2. Two records emerge with rec_seq=1 then 3, each appearing 1 cycle after its input, fields matching the inputs.
- Overflow: rec_ready=0, 10 consecutive faults with DEPTH=8 -> rec_valid=1, drop_cnt=2, head rec_seq=0. After draining, exactly 8 records come out, seq 0..7.
- Simultaneous full: FIFO full, then 1 fault with rec_ready=1 in the same cycle -> drop_cnt unchanged, occupancy stays 8, tail record holds the new seq.
- Alarm: ALARM_RUN=4, sequence fault,fault,ok,fault×4 -> alarm rises the cycle after the 4th consecutive fault only. force_full=1 tracks alarm. clr_alarm -> alarm=0 next cycle.
- Saturation: CNT_W=4, 20 valid faulting checks -> chk_cnt=fault_cnt=15, no wrap.

Source files
------------

// File: rtl/posit_fault_logger.sv
// posit_fault_logger: sits after the posit add fault checker. Counts checks,
// truncated-mode checks and faults, buffers faulting records for a debug
// consumer, and raises a sticky alarm after a run of consecutive faults.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_fault/in_mode checker result strobe, fault flag, truncated mode
//   in_true_sum/in_used_sum   full-precision and checker posit sums
//   in_true_scale/used_scale  scales of the two sums
//   clr_alarm                 clears alarm and the consecutive-fault run
//   rec_valid/rec_ready       valid/ready handshake for the fault record FIFO head
//   rec_*                     head record fields, rec_seq = check index
//   chk_cnt/trunc_cnt/fault_cnt/drop_cnt  saturating statistics
//   alarm/force_full          sticky alarm and its copy back to the checker
module posit_fault_logger #(
    parameter int unsigned NBITS     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ALARM_RUN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_fault,
    input  logic             in_mode,
    input  logic [NBITS-1:0] in_true_sum,
    input  logic [NBITS-1:0] in_used_sum,
    input  logic [6:0]       in_true_scale,
    input  logic [6:0]       in_used_scale,
    input  logic             clr_alarm,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic             rec_mode,
    output logic [NBITS-1:0] rec_true_sum,
    output logic [NBITS-1:0] rec_used_sum,
    output logic [6:0]       rec_true_scale,
    output logic [6:0]       rec_used_scale,
    output logic [CNT_W-1:0] rec_seq,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] trunc_cnt,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             alarm,
    output logic             force_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] ALARM_TH = CNT_W'(ALARM_RUN);

    typedef struct packed {
        logic             mode;
        logic [NBITS-1:0] true_sum;
        logic [NBITS-1:0] used_sum;
        logic [6:0]       true_scale;
        logic [6:0]       used_scale;
        logic [CNT_W-1:0] seq;
    } rec_t;

    typedef enum logic {NORMAL = 1'b0, ALARM = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    rec_t           mem [DEPTH];
    rec_t           head_q, head_n, new_rec_c;
    logic           head_vld_q, head_vld_n;
    logic [PW-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic           full_c, push_c, pop_c, wr_en_c, drop_c;
    state_t         state, state_n;
    logic [CNT_W-1:0] run_q, run_n;

    // FIFO control: full when pointers differ only in the wrap bit
    always_comb begin
        full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        push_c    = in_valid & in_fault;
        pop_c     = head_vld_q & rec_ready;
        wr_en_c   = push_c & (~full_c | pop_c);
        drop_c    = push_c & full_c & ~pop_c;
        wr_ptr_n  = wr_ptr + PW'(wr_en_c);
        rd_ptr_n  = rd_ptr + PW'(pop_c);
        new_rec_c = '{mode: in_mode, true_sum: in_true_sum, used_sum: in_used_sum,
                      true_scale: in_true_scale, used_scale: in_used_scale, seq: chk_cnt};
    end

    // Registered head: the slot being written this cycle is not yet in mem
    always_comb begin
        head_vld_n = (wr_ptr_n != rd_ptr_n);
        head_n     = '0;
        if (head_vld_n) begin
            if (wr_en_c && (rd_ptr_n == wr_ptr))
                head_n = new_rec_c;
            else
                head_n = mem[rd_ptr_n[AW-1:0]];
        end
    end

    // Record storage, no reset needed (head register masks stale contents)
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c)
            mem[wr_ptr[AW-1:0]] <= new_rec_c;
    end

    // FIFO pointers, head register and statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            chk_cnt    <= '0;
            trunc_cnt  <= '0;
            fault_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            head_q     <= head_n;
            head_vld_q <= head_vld_n;
            if (in_valid) begin
                chk_cnt <= sat_inc(chk_cnt);
                if (in_mode)  trunc_cnt <= sat_inc(trunc_cnt);
                if (in_fault) fault_cnt <= sat_inc(fault_cnt);
            end
            if (drop_c) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    // Alarm FSM: state register (with run counter)
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
            run_q <= '0;
        end else begin
            state <= state_n;
            run_q <= run_n;
        end
    end

    // Alarm FSM next state: clear is applied before the current check counts
    always_comb begin
        state_n = state;
        run_n   = clr_alarm ? '0 : run_q;
        if (in_valid)
            run_n = in_fault ? sat_inc(run_n) : '0;
        if (state == ALARM && clr_alarm)
            state_n = NORMAL;
        if (state_n == NORMAL && push_c && run_n == ALARM_TH)
            state_n = ALARM;
    end

    // Alarm FSM outputs, decoded from the state flop
    always_comb begin
        alarm      = (state == ALARM);
        force_full = (state == ALARM);
    end

    assign rec_valid      = head_vld_q;
    assign rec_mode       = head_q.mode;
    assign rec_true_sum   = head_q.true_sum;
    assign rec_used_sum   = head_q.used_sum;
    assign rec_true_scale = head_q.true_scale;
    assign rec_used_scale = head_q.used_scale;
    assign rec_seq        = head_q.seq;

endmodule

// File: tb/tb_posit_fault_logger.sv
module tb_posit_fault_logger;

    localparam int unsigned NB  = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned CWS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_fault = 1'b0, in_mode = 1'b0, clr_alarm = 1'b0;
    logic [NB-1:0] in_true_sum = '0, in_used_sum = '0;
    logic [6:0]    in_true_scale = '0, in_used_scale = '0;
    logic          rec_ready = 1'b0;

    logic          rec_valid, rec_mode, alarm, force_full;
    logic [NB-1:0] rec_true_sum, rec_used_sum;
    logic [6:0]    rec_true_scale, rec_used_scale;
    logic [CW-1:0] rec_seq, chk_cnt, trunc_cnt, fault_cnt, drop_cnt;

    logic           s_rec_valid, s_rec_mode, s_alarm, s_force_full;
    logic [NB-1:0]  s_rec_true_sum, s_rec_used_sum;
    logic [6:0]     s_rec_true_scale, s_rec_used_scale;
    logic [CWS-1:0] s_rec_seq, s_chk_cnt, s_trunc_cnt, s_fault_cnt, s_drop_cnt;

    posit_fault_logger #(.NBITS(NB), .DEPTH(8), .CNT_W(CW), .ALARM_RUN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_fault(in_fault), .in_mode(in_mode),
        .in_true_sum(in_true_sum), .in_used_sum(in_used_sum),
        .in_true_scale(in_true_scale), .in_used_scale(in_used_scale),
        .clr_alarm(clr_alarm), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_mode(rec_mode), .rec_true_sum(rec_true_sum), .rec_used_sum(rec_used_sum),
        .rec_true_scale(rec_true_scale), .rec_used_scale(rec_used_scale), .rec_seq(rec_seq),
        .chk_cnt(chk_cnt), .trunc_cnt(trunc_cnt), .fault_cnt(fault_cnt), .drop_cnt(drop_cnt),
        .alarm(alarm), .force_full(force_full)
    );

    posit_fault_logger #(.NBITS(NB), .DEPTH(8), .CNT_W(CWS), .ALARM_RUN(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_fault(in_fault), .in_mode(in_mode),
        .in_true_sum(in_true_sum), .in_used_sum(in_used_sum),
        .in_true_scale(in_true_scale), .in_used_scale(in_used_scale),
        .clr_alarm(clr_alarm), .rec_valid(s_rec_valid), .rec_ready(rec_ready),
        .rec_mode(s_rec_mode), .rec_true_sum(s_rec_true_sum), .rec_used_sum(s_rec_used_sum),
        .rec_true_scale(s_rec_true_scale), .rec_used_scale(s_rec_used_scale), .rec_seq(s_rec_seq),
        .chk_cnt(s_chk_cnt), .trunc_cnt(s_trunc_cnt), .fault_cnt(s_fault_cnt), .drop_cnt(s_drop_cnt),
        .alarm(s_alarm), .force_full(s_force_full)
    );

    typedef struct {
        logic          mode;
        logic [NB-1:0] ts;
        logic [NB-1:0] us;
        logic [6:0]    tsc;
        logic [6:0]    usc;
        logic [CW-1:0] seq;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0, pop_cnt = 0, nseq = 0;
    logic [CW-1:0] last_seq = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: compares every accepted head record with the queue front
    always @(negedge clk) begin
        exp_t e;
        if (!rst && rec_valid && rec_ready) begin
            if (q.size() == 0) begin
                check("rec_unexpected", 64'(rec_seq), 64'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("rec_seq",        64'(rec_seq),        64'(e.seq));
                check("rec_mode",       64'(rec_mode),       64'(e.mode));
                check("rec_true_sum",   64'(rec_true_sum),   64'(e.ts));
                check("rec_used_sum",   64'(rec_used_sum),   64'(e.us));
                check("rec_true_scale", 64'(rec_true_scale), 64'(e.tsc));
                check("rec_used_scale", 64'(rec_used_scale), 64'(e.usc));
                last_seq = rec_seq;
                pop_cnt++;
            end
        end
    end

    // One clock of stimulus; record fields are derived from the check index
    task automatic cyc(input logic v, input logic f, input logic m, input logic c,
                       input logic r, input bit exp_rec);
        @(posedge clk); #1;
        in_valid      = v;
        in_fault      = f;
        in_mode       = m;
        clr_alarm     = c;
        rec_ready     = r;
        in_true_sum   = 32'hC000_0000 | 32'(nseq * 3 + 1);
        in_used_sum   = 32'h4000_0000 | 32'(nseq * 5);
        in_true_scale = 7'(nseq + 2);
        in_used_scale = 7'(nseq + 40);
        if (v && f && exp_rec)
            q.push_back('{mode: m, ts: in_true_sum, us: in_used_sum,
                          tsc: in_true_scale, usc: in_used_scale, seq: CW'(nseq)});
        if (v) nseq++;
    endtask

    task automatic settle(input logic r);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, r, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; in_fault = 1'b1; rec_ready = 1'b0; clr_alarm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; in_fault = 1'b0;
        nseq = 0;
        q.delete();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_chk"},   64'(chk_cnt),   64'd0);
        check({tag, "_trunc"}, 64'(trunc_cnt), 64'd0);
        check({tag, "_fault"}, 64'(fault_cnt), 64'd0);
        check({tag, "_drop"},  64'(drop_cnt),  64'd0);
        check({tag, "_valid"}, 64'(rec_valid), 64'd0);
        check({tag, "_seq"},   64'(rec_seq),   64'd0);
        check({tag, "_tsum"},  64'(rec_true_sum), 64'd0);
        check({tag, "_alarm"}, 64'(alarm),     64'd0);
        check({tag, "_ff"},    64'(force_full), 64'd0);
        check({tag, "_s_chk"}, 64'(s_chk_cnt), 64'd0);
    endtask

    initial begin
        logic prev_f, f;

        // Reset held two cycles with a faulting check on the inputs
        do_reset();
        check_reset_state("rst");

        // Logging: faults on checks 1 and 3, truncated mode throughout
        prev_f = 1'b0;
        for (int i = 0; i < 5; i++) begin
            f = (i == 1) || (i == 3);
            cyc(1'b1, f, 1'b1, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            check("log_latency_valid", 64'(rec_valid), 64'(prev_f));
            if (prev_f) check("log_latency_seq", 64'(rec_seq), 64'(i - 1));
            prev_f = f;
        end
        settle(1'b1);
        check("log_latency_valid", 64'(rec_valid), 64'(prev_f));
        settle(1'b1);
        check("log_chk",   64'(chk_cnt),   64'd5);
        check("log_trunc", 64'(trunc_cnt), 64'd5);
        check("log_fault", 64'(fault_cnt), 64'd2);
        check("log_pops",  64'(pop_cnt),   64'd2);
        check("log_empty", 64'(rec_valid), 64'd0);

        // Overflow: 10 faults into an 8-deep FIFO with no consumer
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, i < 8);
        settle(1'b0);
        check("ovf_valid", 64'(rec_valid), 64'd1);
        check("ovf_drop",  64'(drop_cnt),  64'd2);
        check("ovf_head",  64'(rec_seq),   64'd0);
        check("ovf_fault", 64'(fault_cnt), 64'd10);
        pop_cnt = 0;
        repeat (12) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("ovf_pops",   64'(pop_cnt),  64'd8);
        check("ovf_last",   64'(last_seq), 64'd7);
        check("ovf_drained", 64'(rec_valid), 64'd0);

        // Simultaneous write and pop on a full FIFO
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        pop_cnt = 0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle(1'b0);
        check("sim_drop", 64'(drop_cnt), 64'd2);
        check("sim_head", 64'(rec_seq),  64'd11);
        check("sim_pops", 64'(pop_cnt),  64'd1);
        // Still full: the next fault without a pop is dropped
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle(1'b0);
        check("sim_full_drop", 64'(drop_cnt), 64'd3);
        repeat (12) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("sim_pops_total", 64'(pop_cnt),  64'd9);
        check("sim_tail_seq",   64'(last_seq), 64'd18);
        check("sim_q_empty",    64'(q.size()), 64'd0);

        // Alarm: F,F,ok,F,F,F,F raises alarm only after the 4th consecutive fault
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, i != 2, 1'b0, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            check("alm_low", 64'(alarm), 64'd0);
        end
        settle(1'b1);
        check("alm_high", 64'(alarm),      64'd1);
        check("alm_ff",   64'(force_full), 64'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        settle(1'b1);
        check("alm_clr",    64'(alarm),      64'd0);
        check("alm_clr_ff", 64'(force_full), 64'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle(1'b1);
        check("alm_rearm", 64'(alarm), 64'd1);
        // Clear together with a fault: the fault starts a new run of 1
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        settle(1'b1);
        check("alm_clr_trig", 64'(alarm), 64'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle(1'b1);
        check("alm_run3", 64'(alarm), 64'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        settle(1'b1);
        check("alm_run4", 64'(alarm), 64'd1);
        settle(1'b1);
        check("alm_q_empty", 64'(q.size()), 64'd0);

        // Reset mid-operation discards buffered records and counters
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle(1'b0);
        check("mid_valid_pre", 64'(rec_valid), 64'd1);
        do_reset();
        check_reset_state("mid");

        // Saturation on the 4-bit instance, 20 faulting truncated checks
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, i < 8);
        settle(1'b0);
        check("sat_chk",   64'(s_chk_cnt),   64'd15);
        check("sat_fault", 64'(s_fault_cnt), 64'd15);
        check("sat_trunc", 64'(s_trunc_cnt), 64'd15);
        check("sat_drop",  64'(s_drop_cnt),  64'd12);
        check("sat_wide_chk",  64'(chk_cnt),  64'd20);
        check("sat_wide_drop", 64'(drop_cnt), 64'd12);
        repeat (12) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("sat_q_empty", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
